ledarb: RTL and testbench

Round-robin arbiter that shares the board LED bank between NREQ on-chip requesters (status monitors, the CPU's LED register, a bouncer pattern), each holding ownership for a programmable minimum dwell time. A Wishbone slave port provides the dwell setting, a per-requester enable mask, and a CPU force override. The arbiter sits between the requesters and the LED pins, and its `o_led` drives the pads directly.

---
 rtl/ledarb.sv | 232 +++++++++++++++++++++++
 tb/tb_ledarb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledarb.sv
`default_nettype none
// ============================================================================
//  Module   : ledarb
//  Purpose  : Round-robin arbiter sharing the board LED bank between NREQ
//             on-chip requesters. Each owner keeps the LEDs for at least
//             DWELL+1 cycles. A Wishbone slave exposes the dwell setting, a
//             per-requester enable mask and a CPU force override.
//  Ports    : i_clk, i_reset      - clock, synchronous active-high reset
//             i_req, i_req_led    - request levels and per-requester LED data
//             o_grant, o_led      - registered one-hot grant and LED pad drive
//             i_wb_*              - Wishbone pipelined slave inputs
//             o_wb_ack/stall/data - Wishbone slave outputs
//  Revision : 1.0  initial release
// ============================================================================
module ledarb #(
    parameter int                    NREQ          = 4,
    parameter int                    NLEDS         = 8,
    parameter int                    DWELL_BITS    = 24,
    parameter logic [DWELL_BITS-1:0] DEFAULT_DWELL = DWELL_BITS'(10_000_000)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*NLEDS-1:0] i_req_led,
    output logic [NREQ-1:0]       o_grant,
    output logic [NLEDS-1:0]      o_led,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [1:0]            i_wb_addr,
    input  logic [31:0]           i_wb_data,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [31:0]           o_wb_data
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OWN   = 2'd1;
    localparam logic [1:0] c_FORCE = 2'd2;

    // Control registers
    logic                  r_force;
    logic [NREQ-1:0]       r_enmask;
    logic [NLEDS-1:0]      r_force_led;
    logic [DWELL_BITS-1:0] r_dwell;

    // Arbiter state
    logic [1:0]            r_state;
    logic [2:0]            r_owner;
    logic [2:0]            r_last;
    logic [DWELL_BITS-1:0] r_cnt;
    logic [NREQ-1:0]       r_grant;
    logic [NLEDS-1:0]      r_led;

    logic                  r_ack;
    logic [31:0]           r_rdata;

    // A CTRL write is seen by the arbiter on the same edge it lands, so a
    // FORCE write racing a fresh request resolves to FORCE.
    logic                  w_ctrl_wr;
    logic                  w_dwell_wr;
    logic                  w_force;
    logic [NREQ-1:0]       w_enmask;
    logic [NLEDS-1:0]      w_force_led;

    logic [NREQ-1:0]       w_elig;
    logic [NREQ-1:0]       w_cand;
    logic [NREQ-1:0]       w_own_oh;
    logic [NREQ-1:0]       w_win_oh;
    logic                  w_own_elig;
    logic [NLEDS-1:0]      w_own_led;
    logic [2:0]            w_win;
    logic                  w_found;
    logic [31:0]           w_ctrl;
    logic [31:0]           w_status;
    logic                  w_unused;

    assign w_ctrl_wr   = i_wb_stb & i_wb_we & (i_wb_addr == 2'd0);
    assign w_dwell_wr  = i_wb_stb & i_wb_we & (i_wb_addr == 2'd1);
    assign w_force     = w_ctrl_wr ? i_wb_data[31]       : r_force;
    assign w_enmask    = w_ctrl_wr ? i_wb_data[8 +: NREQ] : r_enmask;
    assign w_force_led = w_ctrl_wr ? i_wb_data[NLEDS-1:0] : r_force_led;

    assign w_elig     = i_req & w_enmask;
    assign w_own_oh   = NREQ'(1) << r_owner;
    assign w_own_elig = |(w_elig & w_own_oh);
    // While owning, the current owner is excluded so a handover always moves on.
    assign w_cand     = (r_state == c_OWN) ? (w_elig & ~w_own_oh) : w_elig;
    assign w_win_oh   = NREQ'(1) << w_win;

    // Round-robin pick: smallest forward distance from last_owner+1.
    always_comb begin : rr_search
        int best;
        int d;
        best    = NREQ;
        d       = 0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            d = k - int'(r_last) - 1;
            if (d < 0) d = d + NREQ;
            if (w_cand[k] && (d < best)) begin
                best    = d;
                w_win   = 3'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin : own_led_mux
        w_own_led = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_owner == 3'(k)) w_own_led = i_req_led[k*NLEDS +: NLEDS];
        end
    end

    always_comb begin : readback
        w_ctrl              = '0;
        w_ctrl[31]          = r_force;
        w_ctrl[8 +: NREQ]   = r_enmask;
        w_ctrl[NLEDS-1:0]   = r_force_led;
        w_status            = '0;
        w_status[31:30]     = r_state;
        w_status[18:16]     = r_owner;
        w_status[8 +: NREQ] = r_grant;
        w_status[0 +: NLEDS] = r_led;
    end

    // Register file and Wishbone response
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_force     <= 1'b0;
            r_enmask    <= '1;
            r_force_led <= '0;
            r_dwell     <= DEFAULT_DWELL;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_ack <= i_wb_stb;
            if (w_ctrl_wr) begin
                r_force     <= i_wb_data[31];
                r_enmask    <= i_wb_data[8 +: NREQ];
                r_force_led <= i_wb_data[NLEDS-1:0];
            end
            if (w_dwell_wr) r_dwell <= i_wb_data[DWELL_BITS-1:0];
            if (i_wb_stb) begin
                case (i_wb_addr)
                    2'd0:    r_rdata <= w_ctrl;
                    2'd1:    r_rdata <= 32'(r_dwell);
                    2'd2:    r_rdata <= w_status;
                    default: r_rdata <= '0;
                endcase
            end
        end
    end

    // Arbiter FSM; grant and LED outputs are registered per next state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_IDLE;
            r_owner <= '0;
            r_last  <= 3'(NREQ - 1);
            r_cnt   <= '0;
            r_grant <= '0;
            r_led   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_grant <= '0;
                    r_led   <= '0;
                    if (w_force) begin
                        r_state <= c_FORCE;
                        r_led   <= w_force_led;
                    end else if (w_found) begin
                        r_state <= c_OWN;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= r_dwell;
                        r_grant <= w_win_oh;
                    end
                end
                c_OWN: begin
                    if (w_force) begin
                        r_state <= c_FORCE;
                        r_grant <= '0;
                        r_led   <= w_force_led;
                    end else if (!w_own_elig) begin
                        // Owner gone: one idle cycle before re-arbitration.
                        r_state <= c_IDLE;
                        r_grant <= '0;
                        r_led   <= '0;
                    end else begin
                        r_led <= w_own_led;
                        if ((r_cnt == '0) && w_found) begin
                            r_owner <= w_win;
                            r_last  <= w_win;
                            r_cnt   <= r_dwell;
                            r_grant <= w_win_oh;
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                c_FORCE: begin
                    r_grant <= '0;
                    if (w_force) begin
                        r_led <= w_force_led;
                    end else begin
                        r_state <= c_IDLE;
                        r_led   <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign o_grant    = r_grant;
    assign o_led      = r_led;
    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;

    // Cycle is not qualified; only some write-data bits map to registers.
    assign w_unused = &{1'b0, i_wb_cyc, i_wb_data};

endmodule
`default_nettype wire

// File: tb/tb_ledarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ledarb
//  Purpose  : Self-checking bench for ledarb: directed scenarios followed by
//             randomized requests and register traffic, compared every cycle
//             against a rule-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ledarb;

    localparam int          NREQ  = 4;
    localparam int          NLEDS = 8;
    localparam logic [31:0] c_DEF = 32'd10_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_led;
    logic [3:0]  grant;
    logic [7:0]  led;
    logic        cyc, stb, we;
    logic [1:0]  addr;
    logic [31:0] wdat;
    logic        ack, stall;
    logic [31:0] rdat;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_state, m_owner, m_last;
    logic [31:0] m_cnt, m_dwell, m_rdata;
    logic [3:0]  m_grant, m_enmask;
    logic [7:0]  m_led, m_fled;
    logic        m_force, m_ack;

    ledarb #(.NREQ(NREQ), .NLEDS(NLEDS), .DWELL_BITS(24)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_req     (req),
        .i_req_led (req_led),
        .o_grant   (grant),
        .o_led     (led),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_addr (addr),
        .i_wb_data (wdat),
        .o_wb_ack  (ack),
        .o_wb_stall(stall),
        .o_wb_data (rdat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester in 'set' going upward from 'from'+1 with wrap-around.
    function automatic int rr_pick(input logic [3:0] set, input int from);
        for (int d = 1; d <= NREQ; d++) begin
            int k;
            k = (from + d) % NREQ;
            if (set[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic        nf;
        logic [3:0]  nm, el, others;
        logic [7:0]  nfl, oled;
        logic [31:0] nd;
        int          w;
        if (rst) begin
            m_state = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
            m_grant = 0; m_led = 0; m_force = 0; m_enmask = 4'hF;
            m_fled = 0; m_dwell = c_DEF; m_ack = 0; m_rdata = 0;
            return;
        end
        m_ack = stb;
        if (stb) begin
            case (addr)
                2'd0:    m_rdata = {m_force, 19'b0, m_enmask, m_fled};
                2'd1:    m_rdata = m_dwell;
                2'd2:    m_rdata = {2'(m_state), 11'b0, 3'(m_owner), 4'b0, m_grant, m_led};
                default: m_rdata = 0;
            endcase
        end
        nf = m_force; nm = m_enmask; nfl = m_fled; nd = m_dwell;
        if (stb && we && addr == 2'd0) begin
            nf = wdat[31]; nm = wdat[11:8]; nfl = wdat[7:0];
        end
        if (stb && we && addr == 2'd1) nd = {8'b0, wdat[23:0]};
        el   = req & nm;
        oled = req_led[m_owner*8 +: 8];
        case (m_state)
            0: begin
                m_grant = 0; m_led = 0;
                if (nf) begin
                    m_state = 2; m_led = nfl;
                end else if (el != 0) begin
                    w = rr_pick(el, m_last);
                    m_owner = w; m_last = w; m_cnt = m_dwell;
                    m_grant = 4'b1 << w; m_state = 1;
                end
            end
            1: begin
                if (nf) begin
                    m_state = 2; m_grant = 0; m_led = nfl;
                end else if (!el[m_owner]) begin
                    m_state = 0; m_grant = 0; m_led = 0;
                end else begin
                    others = el & ~(4'b1 << m_owner);
                    m_led  = oled;
                    if (m_cnt == 0 && others != 0) begin
                        w = rr_pick(others, m_owner);
                        m_owner = w; m_last = w; m_cnt = m_dwell;
                        m_grant = 4'b1 << w;
                    end else if (m_cnt != 0) begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
            default: begin
                m_grant = 0;
                if (nf) m_led = nfl;
                else begin
                    m_state = 0; m_led = 0;
                end
            end
        endcase
        m_force = nf; m_enmask = nm; m_fled = nfl; m_dwell = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("grant", grant, m_grant);
        check("led", led, m_led);
        check("ack", ack, m_ack);
        if (m_ack) check("rdata", rdat, m_rdata);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        stb = 1; we = 1; addr = a; wdat = d;
        tick();
        stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [1:0] a);
        stb = 1; we = 0; addr = a;
        tick();
        stb = 0;
    endtask

    function automatic logic [3:0] rot_next(input logic [3:0] g);
        case (g)
            4'b0001: return 4'b0100;
            4'b0100: return 4'b1000;
            4'b1000: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        int          zeros, bad, handovers, run_len, started, seen;
        logic [3:0]  prev;

        rst = 1; req = 0; req_led = 0; cyc = 0; stb = 0; we = 0; addr = 0; wdat = 0;
        repeat (3) tick();
        rst = 0;
        check("rst_grant", grant, 0);
        check("rst_led", led, 0);
        wb_read(2'd1);
        check("rst_dwell", rdat, c_DEF);

        // First grant
        req = 4'b0110; req_led = 32'h0000_A500;
        tick();
        check("first_grant", grant, 4'b0010);
        tick();
        check("first_led", led, 8'hA5);
        wb_read(2'd2);
        check("status_owner", rdat[18:16], 3'd1);

        // Force override while owner 1 holds
        wb_write(2'd0, 32'h8000_0F3C);
        check("force_grant", grant, 0);
        check("force_led", led, 8'h3C);
        wb_write(2'd0, 32'h0000_0F00);
        check("force_clear_idle", grant, 0);
        tick();
        check("rr_after_force", grant, 4'b0100);

        // Enable mask removes owner 1
        req = 4'b0010;
        tick(); tick();
        check("mask_pre", grant, 4'b0010);
        req = 4'b0011;
        wb_write(2'd0, 32'h0000_0D00);
        check("mask_drop", grant, 0);
        seen = 0;
        repeat (10) begin
            tick();
            if (grant[1]) seen = 1;
        end
        check("mask_never1", seen, 0);
        wb_write(2'd0, 32'h0000_0F00);

        // Sole requester
        req = 4'b0100;
        tick(); tick();
        bad = 0;
        repeat (100) begin
            tick();
            if (grant != 4'b0100) bad++;
        end
        check("sole_hold", bad, 0);
        req = 0;
        tick();
        check("sole_drop_grant", grant, 0);
        tick();
        check("sole_drop_led", led, 0);

        // Rotation with DWELL = 3
        wb_write(2'd1, 32'd3);
        req = 4'b1101;
        zeros = 0; bad = 0; handovers = 0; run_len = 0; started = 0; prev = 0;
        repeat (30) begin
            tick();
            if (started != 0 && grant == 0) zeros++;
            if (grant != 0) started = 1;
            if (grant != prev && prev != 0 && grant != 0) begin
                handovers++;
                if (grant != rot_next(prev)) bad++;
                if (run_len != 4) bad++;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev = grant;
        end
        check("rot_zero_gaps", zeros, 0);
        check("rot_order_len", bad, 0);
        check("rot_handovers", 32'(handovers >= 5), 1);

        // Reset mid-ownership with a strobe pending
        rst = 1; stb = 1; we = 1; addr = 2'd1; wdat = 32'd5;
        tick();
        check("rst_ack", ack, 0);
        check("rst_grant2", grant, 0);
        check("rst_led2", led, 0);
        rst = 0; stb = 0; we = 0;
        tick();
        wb_read(2'd1);
        check("rst_dwell2", rdat, c_DEF);

        // Back-to-back strobes
        stb = 1; we = 0;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            tick();
            check("b2b_ack", ack, 1);
        end
        stb = 0;
        tick();
        check("ack_low", ack, 0);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            req_led = $urandom;
            stb = ($urandom_range(0, 3) == 0);
            we  = $urandom_range(0, 1) == 1;
            cyc = stb;
            addr = 2'($urandom);
            case (addr)
                2'd0:    wdat = {($urandom_range(0, 3) == 0), 19'b0,
                                 4'($urandom | $urandom), 8'($urandom)};
                2'd1:    wdat = 32'($urandom_range(0, 6));
                default: wdat = $urandom;
            endcase
            tick();
        end
        rst = 0; stb = 0; we = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
